conf_axi_bridge: RTL and testbench



---
 rtl/conf_axi_bridge_if.sv | 62 ++++++
 rtl/conf_axi_bridge.sv | 165 ++++++++++++++++
 tb/tb_conf_axi_bridge.sv | 346 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/conf_axi_bridge_if.sv
// Bus bundle for conf_axi_bridge: sram-like conf_data_* request side plus the uncached AXI master side.
// master = the bridge's view, slave = the CPU/interconnect view.
interface conf_axi_bridge_if;
  logic        conf_data_req;
  logic        conf_data_wr;
  logic [1:0]  conf_data_size;
  logic [31:0] conf_data_addr;
  logic [31:0] conf_data_wdata;
  logic [31:0] conf_data_rdata;
  logic        conf_data_addr_ok;
  logic        conf_data_data_ok;

  logic [31:0] araddr;
  logic [2:0]  arsize;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic        rvalid;
  logic        rready;
  logic [31:0] awaddr;
  logic [2:0]  awsize;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic        bvalid;
  logic        bready;

  // constant AXI attribute fields, single-beat INCR, id 0
  logic [3:0]  arid, awid;
  logic [7:0]  arlen, awlen;
  logic [1:0]  arburst, awburst;
  logic        arlock, awlock;
  logic [3:0]  arcache, awcache;
  logic [2:0]  arprot, awprot;

  modport master (
    input  conf_data_req, conf_data_wr, conf_data_size, conf_data_addr, conf_data_wdata,
    output conf_data_rdata, conf_data_addr_ok, conf_data_data_ok,
    output araddr, arsize, arvalid, input arready,
    input  rdata, rvalid, output rready,
    output awaddr, awsize, awvalid, input awready,
    output wdata, wstrb, wvalid, input wready,
    input  bvalid, output bready,
    output arid, awid, arlen, awlen, arburst, awburst,
    output arlock, awlock, arcache, awcache, arprot, awprot
  );

  modport slave (
    output conf_data_req, conf_data_wr, conf_data_size, conf_data_addr, conf_data_wdata,
    input  conf_data_rdata, conf_data_addr_ok, conf_data_data_ok,
    input  araddr, arsize, arvalid, output arready,
    output rdata, rvalid, input rready,
    input  awaddr, awsize, awvalid, output awready,
    input  wdata, wstrb, wvalid, output wready,
    output bvalid, input bready,
    input  arid, awid, arlen, awlen, arburst, awburst,
    input  arlock, awlock, arcache, awcache, arprot, awprot
  );
endinterface

// File: rtl/conf_axi_bridge.sv
// Uncached conf_data_* to single-beat AXI bridge, one transaction outstanding, strict program order.
// `define CONF_WBUF_EN turns writes into single-entry posted writes drained by a background buffer.
module conf_axi_bridge #(
  parameter logic [31:0] PHYS_MASK = 32'h1FFF_FFFF
) (
  input logic               clk,
  input logic               resetn,
  conf_axi_bridge_if.master bus
);

  typedef enum logic [2:0] {IDLE, RD_AR, RD_R, WR_REQ, WR_B, DONE} state_t;

  typedef struct packed {
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } req_t;

  state_t      state;
  req_t        rq;
  logic        arvalid_q, rready_q, awvalid_q, wvalid_q, bready_q, data_ok_q;
  logic        aw_done, w_done;
  logic [31:0] rdata_q;
  logic        addr_ok, accept, aw_hs, w_hs, b_hs, wr_issue;

  function automatic logic [3:0] strb_of(input logic [1:0] size, input logic [1:0] a);
    case (size)
      2'd0:    strb_of = 4'b0001 << a;
      2'd1:    strb_of = a[1] ? 4'b1100 : 4'b0011;
      default: strb_of = 4'b1111;
    endcase
  endfunction

`ifdef CONF_WBUF_EN
  logic wbuf_busy;
  // any new request waits for the posted write's B so MMIO order holds
  assign addr_ok  = (state == IDLE) && !wbuf_busy;
  assign wr_issue = wbuf_busy && !bready_q;
`else
  assign addr_ok  = (state == IDLE);
  assign wr_issue = (state == WR_REQ);
`endif

  assign accept = bus.conf_data_req && addr_ok;
  assign aw_hs  = awvalid_q && bus.awready;
  assign w_hs   = wvalid_q && bus.wready;
  assign b_hs   = bready_q && bus.bvalid;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= IDLE;
      rq        <= '0;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      bready_q  <= 1'b0;
      data_ok_q <= 1'b0;
      aw_done   <= 1'b0;
      w_done    <= 1'b0;
      rdata_q   <= '0;
`ifdef CONF_WBUF_EN
      wbuf_busy <= 1'b0;
`endif
    end else begin
      data_ok_q <= 1'b0;
      case (state)
        IDLE: if (accept) begin
          rq.size  <= bus.conf_data_size;
          rq.addr  <= bus.conf_data_addr & PHYS_MASK;
          rq.wdata <= bus.conf_data_wdata;
          rq.wstrb <= strb_of(bus.conf_data_size, bus.conf_data_addr[1:0]);
          if (!bus.conf_data_wr) begin
            arvalid_q <= 1'b1;
            state     <= RD_AR;
          end else begin
            awvalid_q <= 1'b1;
            wvalid_q  <= 1'b1;
`ifdef CONF_WBUF_EN
            wbuf_busy <= 1'b1;
            data_ok_q <= 1'b1;
            state     <= DONE;
`else
            state     <= WR_REQ;
`endif
          end
        end
        RD_AR: if (bus.arready) begin
          arvalid_q <= 1'b0;
          rready_q  <= 1'b1;
          state     <= RD_R;
        end
        RD_R: if (bus.rvalid) begin
          rready_q  <= 1'b0;
          rdata_q   <= bus.rdata;
          data_ok_q <= 1'b1;
          state     <= DONE;
        end
        DONE:    state <= IDLE;
        default: ;  // WR_REQ / WR_B advance in the write-channel logic below
      endcase

      // aw and w retire independently, in either order or together
      if (wr_issue) begin
        if (aw_hs) begin
          awvalid_q <= 1'b0;
          aw_done   <= 1'b1;
        end
        if (w_hs) begin
          wvalid_q <= 1'b0;
          w_done   <= 1'b1;
        end
        if ((aw_done || aw_hs) && (w_done || w_hs)) begin
          aw_done  <= 1'b0;
          w_done   <= 1'b0;
          bready_q <= 1'b1;
`ifndef CONF_WBUF_EN
          state    <= WR_B;
`endif
        end
      end

      if (b_hs) begin
        bready_q  <= 1'b0;
`ifdef CONF_WBUF_EN
        wbuf_busy <= 1'b0;
`else
        data_ok_q <= 1'b1;
        state     <= DONE;
`endif
      end
    end
  end

  assign bus.conf_data_addr_ok = addr_ok;
  assign bus.conf_data_data_ok = data_ok_q;
  assign bus.conf_data_rdata   = rdata_q;

  assign bus.araddr  = rq.addr;
  assign bus.arsize  = {1'b0, rq.size};
  assign bus.arvalid = arvalid_q;
  assign bus.rready  = rready_q;
  assign bus.awaddr  = rq.addr;
  assign bus.awsize  = {1'b0, rq.size};
  assign bus.awvalid = awvalid_q;
  assign bus.wdata   = rq.wdata;
  assign bus.wstrb   = rq.wstrb;
  assign bus.wvalid  = wvalid_q;
  assign bus.bready  = bready_q;

  assign bus.arid    = 4'd0;
  assign bus.awid    = 4'd0;
  assign bus.arlen   = 8'd0;
  assign bus.awlen   = 8'd0;
  assign bus.arburst = 2'b01;
  assign bus.awburst = 2'b01;
  assign bus.arlock  = 1'b0;
  assign bus.awlock  = 1'b0;
  assign bus.arcache = 4'd0;
  assign bus.awcache = 4'd0;
  assign bus.arprot  = 3'd0;
  assign bus.awprot  = 3'd0;

endmodule

// File: tb/tb_conf_axi_bridge.sv
// Scoreboard bench for conf_axi_bridge: CPU driver pushes expected AXI/completion items, a monitor pops and checks.
module tb_conf_axi_bridge;
  localparam logic [31:0] MASK = 32'h1FFF_FFFF;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  conf_axi_bridge_if bus();
  conf_axi_bridge #(.PHYS_MASK(MASK)) dut (.clk(clk), .resetn(resetn), .bus(bus));

  int total = 0;
  int bad = 0;

  typedef struct { logic [31:0] addr; logic [2:0] size; } ax_t;
  typedef struct { logic [31:0] data; logic [3:0] strb; } w_t;
  typedef struct { bit wr; logic [31:0] rdata; } done_t;
  ax_t   q_ar[$], q_aw[$];
  w_t    q_w[$];
  done_t q_done[$];

  int ar_lat = 0, r_lat = 0, aw_lat = 0, w_lat = 0, b_lat = 0;
  bit rand_lat = 0;
  bit rd_ovr = 0;
  logic [31:0] rd_val = '0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] rfun(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
  endfunction

  // bytes touched: naturally aligned group of 2**size bytes holding addr
  function automatic logic [3:0] ref_strb(input int size, input logic [31:0] a);
    int n, off;
    n   = (size >= 2) ? 4 : (1 << size);
    off = (int'(a[1:0]) / n) * n;
    return 4'(((1 << n) - 1) << off);
  endfunction

  // ---------------- AXI slave model ----------------
  initial begin : axi_slave
    bit s_ar, s_r, s_aw, s_w, s_b, r_pend, aw_d, w_d;
    logic [31:0] s_araddr, r_addr;
    int ar_c, r_c, aw_c, w_c, b_c;
    {s_ar, s_r, s_aw, s_w, s_b, r_pend, aw_d, w_d} = '0;
    s_araddr = '0; r_addr = '0;
    ar_c = 0; r_c = 0; aw_c = 0; w_c = 0; b_c = 0;
    bus.arready = 0; bus.rvalid = 0; bus.rdata = '0;
    bus.awready = 0; bus.wready = 0; bus.bvalid = 0;
    forever begin
      @(negedge clk);
      s_ar = bus.arvalid && bus.arready;
      s_r  = bus.rvalid && bus.rready;
      s_aw = bus.awvalid && bus.awready;
      s_w  = bus.wvalid && bus.wready;
      s_b  = bus.bvalid && bus.bready;
      s_araddr = bus.araddr;
      @(posedge clk); #1;
      if (!resetn) begin
        bus.arready = 0; bus.rvalid = 0; bus.awready = 0; bus.wready = 0; bus.bvalid = 0;
        r_pend = 0; aw_d = 0; w_d = 0;
        ar_c = 0; r_c = 0; aw_c = 0; w_c = 0; b_c = 0;
        continue;
      end
      if (bus.arvalid) begin bus.arready = (ar_c >= ar_lat); ar_c++; end
      else begin bus.arready = 0; ar_c = 0; end
      if (bus.awvalid) begin bus.awready = (aw_c >= aw_lat); aw_c++; end
      else begin bus.awready = 0; aw_c = 0; end
      if (bus.wvalid) begin bus.wready = (w_c >= w_lat); w_c++; end
      else begin bus.wready = 0; w_c = 0; end

      if (s_ar) begin r_pend = 1; r_c = 0; r_addr = s_araddr; end
      if (s_r) begin
        bus.rvalid = 0; r_pend = 0; bus.rdata = $urandom;
      end else if (r_pend && !bus.rvalid) begin
        if (r_c >= r_lat) begin
          bus.rvalid = 1;
          bus.rdata  = rd_ovr ? rd_val : rfun(r_addr);
        end else r_c++;
      end

      if (s_aw) aw_d = 1;
      if (s_w)  w_d = 1;
      if (s_b) begin
        bus.bvalid = 0; aw_d = 0; w_d = 0; b_c = 0;
      end else if (aw_d && w_d && !bus.bvalid) begin
        if (b_c >= b_lat) bus.bvalid = 1;
        else b_c++;
      end

      if (rand_lat && (s_r || s_b)) begin
        ar_lat = $urandom_range(0, 3); r_lat = $urandom_range(0, 5);
        aw_lat = $urandom_range(0, 4); w_lat = $urandom_range(0, 4);
        b_lat  = $urandom_range(0, 5);
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  initial begin : monitor
    int cyc, acc_cyc, r_cyc, b_cyc;
    bit busy, open, aw_s, w_s, rd_known, acc_wr, acc, rhs, bhs;
    logic [31:0] last_rd;
    bit p_arv, p_arr, p_awv, p_awr, p_wv, p_wr, p_dok, p_rr, p_rv, p_br, p_bv;
    logic [31:0] p_araddr, p_awaddr, p_wdata;
    logic [2:0]  p_arsize, p_awsize;
    logic [3:0]  p_wstrb;
    ax_t a; w_t w; done_t d;
    cyc = 0; acc_cyc = -10; r_cyc = -10; b_cyc = -10;
    {busy, open, aw_s, w_s, rd_known, acc_wr} = '0;
    last_rd = '0;
    {p_arv, p_arr, p_awv, p_awr, p_wv, p_wr, p_dok, p_rr, p_rv, p_br, p_bv} = '0;
    p_araddr = '0; p_awaddr = '0; p_wdata = '0; p_arsize = '0; p_awsize = '0; p_wstrb = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!resetn) begin
        q_ar.delete(); q_aw.delete(); q_w.delete(); q_done.delete();
        {busy, open, aw_s, w_s, rd_known} = '0;
        {p_arv, p_arr, p_awv, p_awr, p_wv, p_wr, p_dok, p_rr, p_rv, p_br, p_bv} = '0;
        continue;
      end

      if (p_arv && !p_arr)
        chk("ar_hold", 64'({bus.arvalid, bus.araddr, bus.arsize}), 64'({1'b1, p_araddr, p_arsize}));
      if (p_awv && !p_awr)
        chk("aw_hold", 64'({bus.awvalid, bus.awaddr, bus.awsize}), 64'({1'b1, p_awaddr, p_awsize}));
      if (p_wv && !p_wr)
        chk("w_hold", 64'({bus.wvalid, bus.wdata, bus.wstrb}), 64'({1'b1, p_wdata, p_wstrb}));
      if (p_rr && !p_rv) chk("rready_hold", 64'(bus.rready), 64'(1));
      if (p_br && !p_bv) chk("bready_hold", 64'(bus.bready), 64'(1));

      chk("addr_ok", 64'(bus.conf_data_addr_ok), 64'(!(busy || open)));

      acc = bus.conf_data_req && bus.conf_data_addr_ok;
      if (acc) begin
        chk("accept_when_idle", 64'({busy, open}), 64'(0));
        acc_cyc = cyc;
        acc_wr  = bus.conf_data_wr;
      end

      if (bus.arvalid && !p_arv)
        chk("ar_issue", 64'({cyc - acc_cyc == 1, acc_wr}), 64'(2'b10));
      if (bus.awvalid && !p_awv)
        chk("aw_w_issue", 64'({cyc - acc_cyc == 1, acc_wr, bus.wvalid}), 64'(3'b111));
      if (bus.bready && !p_br)
        chk("bready_after_aw_w", 64'({aw_s, w_s}), 64'(2'b11));

      if (bus.arvalid && bus.arready) begin
        if (q_ar.size() == 0) chk("ar_unexpected", 64'(1), 64'(0));
        else begin
          a = q_ar.pop_front();
          chk("araddr", 64'(bus.araddr), 64'(a.addr));
          chk("arsize", 64'(bus.arsize), 64'(a.size));
        end
      end
      if (bus.awvalid && bus.awready) begin
        aw_s = 1;
        if (q_aw.size() == 0) chk("aw_unexpected", 64'(1), 64'(0));
        else begin
          a = q_aw.pop_front();
          chk("awaddr", 64'(bus.awaddr), 64'(a.addr));
          chk("awsize", 64'(bus.awsize), 64'(a.size));
        end
      end
      if (bus.wvalid && bus.wready) begin
        w_s = 1;
        if (q_w.size() == 0) chk("w_unexpected", 64'(1), 64'(0));
        else begin
          w = q_w.pop_front();
          chk("wdata", 64'(bus.wdata), 64'(w.data));
          chk("wstrb", 64'(bus.wstrb), 64'(w.strb));
        end
      end

      rhs = bus.rvalid && bus.rready;
      bhs = bus.bvalid && bus.bready;
      if (rhs) r_cyc = cyc;
      if (bhs) begin b_cyc = cyc; aw_s = 0; w_s = 0; end

      if (bus.conf_data_data_ok) begin
        chk("data_ok_pulse", 64'(p_dok), 64'(0));
        if (q_done.size() == 0) chk("data_ok_unexpected", 64'(1), 64'(0));
        else begin
          d = q_done.pop_front();
          if (!d.wr) begin
            chk("conf_rdata", 64'(bus.conf_data_rdata), 64'(d.rdata));
            chk("rd_latency", 64'(cyc - r_cyc), 64'(1));
            last_rd = d.rdata; rd_known = 1;
          end else begin
            if (rd_known) chk("rdata_held", 64'(bus.conf_data_rdata), 64'(last_rd));
`ifdef CONF_WBUF_EN
            chk("wr_posted_latency", 64'(cyc - acc_cyc), 64'(1));
`else
            chk("wr_done_after_b", 64'(cyc - b_cyc), 64'(1));
`endif
          end
        end
      end

      if (acc) begin busy = 1; open = 1; end
      if (rhs || bhs) open = 0;
      if (bus.conf_data_data_ok) busy = 0;

      p_arv = bus.arvalid; p_arr = bus.arready; p_awv = bus.awvalid; p_awr = bus.awready;
      p_wv = bus.wvalid; p_wr = bus.wready; p_dok = bus.conf_data_data_ok;
      p_rr = bus.rready; p_rv = bus.rvalid; p_br = bus.bready; p_bv = bus.bvalid;
      p_araddr = bus.araddr; p_arsize = bus.arsize; p_awaddr = bus.awaddr; p_awsize = bus.awsize;
      p_wdata = bus.wdata; p_wstrb = bus.wstrb;
    end
  end

  // ---------------- CPU-side driver ----------------
  task automatic issue(input bit wr, input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d);
    int n;
    bit ok;
    n = 0; ok = 0;
    @(posedge clk); #1;
    bus.conf_data_req = 1; bus.conf_data_wr = wr; bus.conf_data_size = sz;
    bus.conf_data_addr = a; bus.conf_data_wdata = d;
    while (!ok && n < 300) begin
      @(negedge clk);
      ok = bus.conf_data_addr_ok;
      n++;
    end
    if (!ok) chk("accept_timeout", 64'(0), 64'(1));
    @(posedge clk); #1;
    bus.conf_data_req = 0;
    if (ok) begin
      if (wr) begin
        q_aw.push_back('{a & MASK, {1'b0, sz}});
        q_w.push_back('{d, ref_strb(int'(sz), a)});
        q_done.push_back('{1'b1, 32'h0});
      end else begin
        q_ar.push_back('{a & MASK, {1'b0, sz}});
        q_done.push_back('{1'b0, rd_ovr ? rd_val : rfun(a & MASK)});
      end
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(bus.conf_data_addr_ok && q_done.size() == 0) && n < 500);
    if (n >= 500) chk("idle_timeout", 64'(0), 64'(1));
  endtask

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int n;
    bus.conf_data_req = 0; bus.conf_data_wr = 0; bus.conf_data_size = '0;
    bus.conf_data_addr = '0; bus.conf_data_wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valids", 64'({bus.arvalid, bus.rready, bus.awvalid, bus.wvalid, bus.bready, bus.conf_data_data_ok}), 64'(0));
    chk("rst_payload", 64'({bus.araddr, bus.wstrb, bus.arsize}), 64'(0));
    chk("tieoffs", 64'({bus.arid, bus.awid, bus.arlen, bus.awlen, bus.arburst, bus.awburst,
                       bus.arlock, bus.awlock, bus.arcache, bus.awcache, bus.arprot, bus.awprot}),
        64'({4'd0, 4'd0, 8'd0, 8'd0, 2'b01, 2'b01, 1'b0, 1'b0, 4'd0, 4'd0, 3'd0, 3'd0}));
    @(negedge clk) resetn = 1;
    @(negedge clk);
    chk("addr_ok_after_reset", 64'(bus.conf_data_addr_ok), 64'(1));

    // directed read through kseg1
    r_lat = 3; rd_ovr = 1; rd_val = 32'h1234_5678;
    issue(0, 2'd2, 32'hBFAF_F000, 32'h0);
    wait_idle();
    rd_ovr = 0; r_lat = 0;
    chk("rdata_final", 64'(bus.conf_data_rdata), 64'(32'h1234_5678));

    // byte write to top lane
    b_lat = 2;
    issue(1, 2'd0, 32'hBFD0_0003, 32'hAA00_0000);
    wait_idle();
    chk("rdata_kept_after_write", 64'(bus.conf_data_rdata), 64'(32'h1234_5678));

    // awready late, wready immediate
    aw_lat = 3; w_lat = 0; b_lat = 1;
    issue(1, 2'd2, 32'hBFC0_0100, 32'hDEAD_BEEF);
    wait_idle();
    aw_lat = 0; b_lat = 0;

    // wready late, awready immediate
    w_lat = 2;
    issue(1, 2'd1, 32'hBFC0_0106, 32'h7777_7777);
    wait_idle();
    w_lat = 0;

    // back-to-back read then write, all readies immediate
    issue(0, 2'd1, 32'hA000_0042, 32'h0);
    issue(1, 2'd1, 32'hA000_0046, 32'h5555_6666);
    wait_idle();

    // randomized traffic and latencies
    rand_lat = 1;
    repeat (60) begin
      repeat ($urandom_range(0, 2)) @(posedge clk);
      issue(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), $urandom, $urandom);
    end
    wait_idle();
    rand_lat = 0;
    ar_lat = 0; r_lat = 0; aw_lat = 0; w_lat = 0; b_lat = 0;

    // asynchronous reset while waiting for R
    r_lat = 30;
    issue(0, 2'd2, 32'hBFC0_0000, 32'h0);
    n = 0;
    while (!bus.rready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("rready_seen", 64'(bus.rready), 64'(1));
    @(negedge clk);
    #2 resetn = 0;
    #1;
    chk("async_reset_outputs", 64'({bus.arvalid, bus.rready, bus.conf_data_data_ok, bus.awvalid, bus.wvalid, bus.bready}), 64'(0));
    @(negedge clk);
    @(negedge clk) resetn = 1;
    r_lat = 0;
    @(negedge clk);
    chk("addr_ok_after_async_reset", 64'(bus.conf_data_addr_ok), 64'(1));

    issue(0, 2'd0, 32'hBFC0_0011, 32'h0);
    wait_idle();

    chk("queues_drained", 64'({q_ar.size() == 0, q_aw.size() == 0, q_w.size() == 0, q_done.size() == 0}), 64'(4'b1111));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
